i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
// I2C target (responder) that sits on an FPGA-side I2C segment and exposes an 8-bit-addressed
// register space to fabric logic. It decodes START/STOP, matches a 7-bit address and ACKs it.
// A write loads an auto-incrementing pointer and then write data; a read serves data through a
// simple register port. SDA is open-drain (drive 0 or Z); the external pull-up is mandatory.
// No clock stretching. Requirement: clk >= 20x SCL rate.
// PARAMETERS
// SLAVE_ADDR   7'h50  7-bit I2C address this target answers
// SYNC_STAGES  2      flops on scl/sda before edge detection (>=2)
// PORTS
// clk        in     1  system clock
// reset_n    in     1  synchronous, active-low reset
// scl        in     1  I2C clock, sampled only (never driven)
// sda        inout  1  I2C data, open-drain: 1'b0 when sda_oe, else 1'bz
// reg_addr   out    8  register address (= pointer) for reg_wr/reg_rd
// reg_wdata  out    8  write data, valid while reg_wr=1
// reg_wr     out    1  1-clk write strobe
// reg_rd     out    1  1-clk read strobe; reg_rdata sampled on the next clk
// reg_rdata  in     8  read data
// busy       out    1  high from address-match ACK until STOP/START/reset
// BEHAVIOUR
// - Reset (reset_n=0 at clk edge): sda released, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0,
//   busy=0, pointer=0, sync flops=1, state IDLE. A reset mid-transfer releases sda on that edge;
//   the transfer in progress is then ignored until the next START.
// - Conditioning: scl/sda pass through SYNC_STAGES flops; edges are detected on synced values.
// - START = sda fall while scl high; STOP = sda rise while scl high. Both act in every state and
//   take priority over bit activity. START (incl. repeated) -> ADDR with bit count 0 and sda
//   released. STOP -> IDLE, sda released, busy=0.
// - Bits are sampled on scl rise, MSB first. sda_oe changes only on scl fall (2 clks max after).
// - States:
//   IDLE: wait for START.
//   ADDR: shift 8 bits. On the 8th fall: if bits[7:1]==SLAVE_ADDR -> drive ACK, busy=1, go
//     ADDR_ACK; else -> IDLE (no ACK).
//   ADDR_ACK: hold ACK low to the next scl fall, then: R/W=0 -> PTR (release);
//     R/W=1 -> reg_rd pulse with reg_addr=pointer, load reg_rdata, drive MSB -> RDATA.
//   PTR: 8 bits -> pointer; ACK -> PTR_ACK -> WDATA.
//   WDATA: 8 bits. 1 clk after the 8th rise: reg_wr=1, reg_addr=pointer, reg_wdata=byte.
//     Then ACK (WDATA_ACK) and pointer+1; loop to WDATA.
//   RDATA: shift out 8 bits (drive 0 or release per bit). After the 8th fall, release sda
//     -> RDATA_ACK.
//   RDATA_ACK: sample sda at scl rise. 0 (master ACK): pointer+1, reg_rd at the next fall,
//     next byte -> RDATA. 1 (NACK): -> WAIT_STOP.
//   WAIT_STOP: sda released; wait for STOP/START.
// - Pointer is 8 bits and wraps 8'hFF -> 8'h00. Write and read share one pointer, so a write of
//   the pointer only, followed by repeated START + read, reads from that pointer.
// - reg_wr and reg_rd are never high together and each is exactly 1 clk wide. A STOP/START
//   mid-byte discards the partial byte: no strobe, pointer unchanged.
// TESTING
// 1 START,0xA0,0x10,0x5A,0xC3,STOP -> 4 ACKs; reg_wr (0x10,0x5A) then (0x11,0xC3); busy low after STOP
// 2 START,0xA0,0x11,rSTART,0xA1, rdata=0x3C, master NACK -> sda carries 0x3C; reg_rd once, addr 0x11; sda released
// 3 START,0xA2 (wrong addr),0x00,STOP -> no ACK (sda never low), no reg_wr/reg_rd, busy stays 0
// 4 START,0xA0,0xFF,0x11,0x22,STOP -> reg_wr at 0xFF=0x11, then 0x00=0x22 (wrap)
// 5 reset_n=0 mid-read while sda driven 0 -> sda Z at that edge; later START,0xA0 -> ACKed
// 6 START,0xA0,0x20, 4 data bits, STOP -> no reg_wr; pointer stays 0x20 (next read hits 0x20)

Source files
------------

// File: rtl/i2c_slave_regs_if.sv
// Register-side port of the I2C target: the target (master modport) issues
// address/strobes toward fabric registers; fabric (slave modport) returns read data.
interface i2c_slave_regs_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic       reg_rd;
  logic       busy;
  logic [3:0] state_dbg;

  // Handshake: reg_wr/reg_rd are single-clk strobes with no back-pressure;
  // reg_addr/reg_wdata are valid while the strobe is high and reg_rdata must be
  // valid on the clk edge that follows reg_rd.
  modport master (
    output reg_addr, reg_wdata, reg_wr, reg_rd, busy, state_dbg,
    input  reg_rdata
  );
  modport slave (
    input  reg_addr, reg_wdata, reg_wr, reg_rd, busy, state_dbg,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit register space with an auto-incrementing pointer
// shared by writes and reads. Open-drain sda, no clock stretching.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl,
  inout  wire               sda,
  i2c_slave_regs_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             shift, shift_n;
  logic [7:0]             tx, tx_n;
  logic [7:0]             ptr, ptr_n;
  logic                   rw, rw_n;
  logic                   sda_oe, sda_oe_n;
  logic                   busy_q, busy_n;
  logic [7:0]             reg_addr_q, reg_addr_n;
  logic [7:0]             reg_wdata_q, reg_wdata_n;
  logic                   reg_wr_q, reg_wr_n;
  logic                   reg_rd_q, reg_rd_n;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

  assign sda           = sda_oe ? 1'b0 : 1'bz;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync    <= '1;
      sda_sync    <= '1;
      scl_prev    <= 1'b1;
      sda_prev    <= 1'b1;
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      tx          <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
    end else begin
      scl_sync    <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync    <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_prev    <= scl_s;
      sda_prev    <= sda_s;
      state       <= state_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      tx          <= tx_n;
      ptr         <= ptr_n;
      rw          <= rw_n;
      sda_oe      <= sda_oe_n;
      busy_q      <= busy_n;
      reg_addr_q  <= reg_addr_n;
      reg_wdata_q <= reg_wdata_n;
      reg_wr_q    <= reg_wr_n;
      reg_rd_q    <= reg_rd_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    tx_n        = tx;
    ptr_n       = ptr;
    rw_n        = rw;
    sda_oe_n    = sda_oe;
    busy_n      = busy_q;
    reg_addr_n  = reg_addr_q;
    reg_wdata_n = reg_wdata_q;
    reg_wr_n    = 1'b0;
    reg_rd_n    = 1'b0;

    // Read data arrives the clk after reg_rd; put its MSB on the wire right away.
    if (reg_rd_q) begin
      tx_n     = bus.reg_rdata;
      sda_oe_n = ~bus.reg_rdata[7];
    end

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == SLAVE_ADDR) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shift[0];
              state_n  = ADDR_ACK;
            end else begin
              state_n = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (rw) begin
              reg_rd_n   = 1'b1;
              reg_addr_n = ptr;
              state_n    = RDATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            ptr_n    = shift;
            sda_oe_n = 1'b1;
            state_n  = PTR_ACK;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              reg_wr_n    = 1'b1;
              reg_addr_n  = ptr;
              reg_wdata_n = {shift[6:0], sda_s};
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            ptr_n    = ptr + 8'd1;
            state_n  = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = RDATA_ACK;
            end else if (bit_cnt != 4'd0) begin
              tx_n     = {tx[6:0], 1'b0};
              sda_oe_n = ~tx[6];
            end
          end
        end
        RDATA_ACK: begin
          // bit_cnt==1 marks a master ACK seen on this ack-bit's rising edge.
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_n     = ptr + 8'd1;
              bit_cnt_n = 4'd1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && bit_cnt == 4'd1) begin
            reg_rd_n   = 1'b1;
            reg_addr_n = ptr;
            bit_cnt_n  = '0;
            state_n    = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, register-port logger,
// per-scenario tasks with inline comparisons.
module tb_i2c_slave_regs;
  localparam int Q = 100;

  logic       clk;
  logic       reset_n;
  logic       scl;
  logic       sda_drv_low;
  logic [7:0] rdata_val;
  logic       rdata_inv_addr;
  wire        sda;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int          overlap_cnt = 0;
  int          wide_cnt    = 0;
  int          slave_low_cnt = 0;
  int          busy_cnt    = 0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;

  i2c_slave_regs_if bus ();

  pullup (sda);
  assign sda = sda_drv_low ? 1'b0 : 1'bz;
  assign bus.reg_rdata = rdata_inv_addr ? ~bus.reg_addr : rdata_val;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (scl),
    .sda     (sda),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register-port monitor (sampled on negedge) ----------------
  always @(negedge clk) begin
    if (bus.reg_wr === 1'b1) wr_log.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_rd === 1'b1) rd_log.push_back(bus.reg_addr);
    if (bus.reg_wr === 1'b1 && bus.reg_rd === 1'b1) overlap_cnt++;
    if ((prev_wr && bus.reg_wr === 1'b1) || (prev_rd && bus.reg_rd === 1'b1)) wide_cnt++;
    if (!sda_drv_low && sda === 1'b0) slave_low_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    prev_wr <= (bus.reg_wr === 1'b1);
    prev_rd <= (bus.reg_rd === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic align();
    @(negedge clk);
    #2;
  endtask

  task automatic i2c_start();
    sda_drv_low = 1'b0; #Q;
    scl = 1'b1;         #Q;
    sda_drv_low = 1'b1; #Q;
    scl = 1'b0;         #Q;
  endtask

  task automatic i2c_stop();
    sda_drv_low = 1'b1; #Q;
    scl = 1'b1;         #Q;
    sda_drv_low = 1'b0; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_drv_low = ~b; #Q;
    scl = 1'b1;       #(2*Q);
    scl = 1'b0;       #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_drv_low = 1'b0; #Q;
    scl = 1'b1;         #Q;
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    #Q;
    scl = 1'b0;         #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  task automatic clear_logs();
    exp_q.delete();
    wr_log.delete();
    rd_log.delete();
    slave_low_cnt = 0;
    busy_cnt = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00) begin
      failures++;
      $display("FAIL reset_regs: addr=%h wdata=%h, required 00/00", bus.reg_addr, bus.reg_wdata);
    end
    checks++;
    if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: wr=%b rd=%b busy=%b, required 0/0/0", bus.reg_wr, bus.reg_rd, bus.busy);
    end
    checks++;
    if (sda === 1'b0) begin
      failures++;
      $display("FAIL reset_sda: sda=%b, required released", sda);
    end
    checks++;
    if (bus.state_dbg !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d, required 0 (IDLE)", bus.state_dbg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1, a2, a3;
    clear_logs();
    exp_q.push_back(16'h105A);
    exp_q.push_back(16'h11C3);
    align();
    i2c_start();
    write_byte(8'hA0, a0);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL write_busy_hi: busy=%b, required 1", bus.busy);
    end
    write_byte(8'h10, a1);
    write_byte(8'h5A, a2);
    write_byte(8'hC3, a3);
    i2c_stop();
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin
      failures++;
      $display("FAIL write_acks: acks=%b, required 1111", {a0, a1, a2, a3});
    end
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL write_count: reg_wr count=%0d, required %0d", wr_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL write_data%0d: addr/data=%h, required %h", i, wr_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || rd_log.size() != 0) begin
      failures++;
      $display("FAIL write_after_stop: busy=%b reads=%0d, required 0/0", bus.busy, rd_log.size());
    end
  endtask

  task automatic test_read();
    logic a0, a1, a2;
    logic [7:0] d;
    clear_logs();
    rdata_val = 8'h3C;
    align();
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h11, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    read_byte(d, 1'b1);
    sda_drv_low = 1'b0;
    #Q;
    checks++;
    if (sda === 1'b0) begin
      failures++;
      $display("FAIL read_release: sda=%b after NACK, required released", sda);
    end
    i2c_stop();
    checks++;
    if ({a0, a1, a2} !== 3'b111) begin
      failures++;
      $display("FAIL read_acks: acks=%b, required 111", {a0, a1, a2});
    end
    checks++;
    if (d !== 8'h3C) begin
      failures++;
      $display("FAIL read_data: got=%h, required 3c", d);
    end
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 8'h11 || wr_log.size() != 0) begin
      failures++;
      $display("FAIL read_strobes: reads=%0d first=%h writes=%0d, required 1/11/0",
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'hxx, wr_log.size());
    end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    clear_logs();
    align();
    i2c_start();
    write_byte(8'hA2, a0);
    write_byte(8'h00, a1);
    i2c_stop();
    checks++;
    if (a0 !== 1'b0 || a1 !== 1'b0 || slave_low_cnt != 0) begin
      failures++;
      $display("FAIL wrong_addr_ack: acks=%b%b slave_low=%0d, required 00/0", a0, a1, slave_low_cnt);
    end
    checks++;
    if (wr_log.size() != 0 || rd_log.size() != 0 || busy_cnt != 0) begin
      failures++;
      $display("FAIL wrong_addr_quiet: writes=%0d reads=%0d busy_cycles=%0d, required 0/0/0",
               wr_log.size(), rd_log.size(), busy_cnt);
    end
  endtask

  task automatic test_wrap();
    logic a;
    clear_logs();
    exp_q.push_back(16'hFF11);
    exp_q.push_back(16'h0022);
    align();
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'hFF, a);
    write_byte(8'h11, a);
    write_byte(8'h22, a);
    i2c_stop();
    checks++;
    if (wr_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL wrap_count: reg_wr count=%0d, required %0d", wr_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (wr_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL wrap_data%0d: addr/data=%h, required %h", i, wr_log[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic a, b;
    clear_logs();
    rdata_val = 8'h00;
    align();
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h00, a);
    i2c_start();
    write_byte(8'hA1, a);
    read_bit(b);
    read_bit(b);
    checks++;
    if (sda !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pre: sda=%b, required 0 driven by target", sda);
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (sda === 1'b0) begin
      failures++;
      $display("FAIL midreset_release: sda=%b at reset edge, required released", sda);
    end
    @(negedge clk);
    reset_n = 1'b1;
    align();
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, a);
    i2c_stop();
    checks++;
    if (a !== 1'b1) begin
      failures++;
      $display("FAIL midreset_reack: ack=%b, required 1", a);
    end
  endtask

  task automatic test_partial_byte();
    logic a;
    logic [7:0] d;
    clear_logs();
    rdata_inv_addr = 1'b1;
    align();
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h20, a);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    i2c_stop();
    checks++;
    if (wr_log.size() != 0) begin
      failures++;
      $display("FAIL partial_no_wr: reg_wr count=%0d, required 0", wr_log.size());
    end
    i2c_start();
    write_byte(8'hA1, a);
    read_byte(d, 1'b1);
    i2c_stop();
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 8'h20 || d !== 8'hDF) begin
      failures++;
      $display("FAIL partial_ptr: reads=%0d addr=%h data=%h, required 1/20/df",
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 8'hxx, d);
    end
    rdata_inv_addr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic a;
    logic [7:0] d1, d2;
    clear_logs();
    rdata_inv_addr = 1'b1;
    align();
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h30, a);
    i2c_start();
    write_byte(8'hA1, a);
    read_byte(d1, 1'b0);
    read_byte(d2, 1'b1);
    i2c_stop();
    checks++;
    if (d1 !== 8'hCF || d2 !== 8'hCE) begin
      failures++;
      $display("FAIL b2b_data: got=%h,%h required cf,ce", d1, d2);
    end
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 8'h30 || rd_log[1] !== 8'h31) begin
      failures++;
      $display("FAIL b2b_addrs: reads=%0d, required 2 at 30,31", rd_log.size());
    end
    checks++;
    if (overlap_cnt != 0 || wide_cnt != 0) begin
      failures++;
      $display("FAIL strobe_shape: overlap=%0d wide=%0d, required 0/0", overlap_cnt, wide_cnt);
    end
    rdata_inv_addr = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n        = 1'b0;
    scl            = 1'b1;
    sda_drv_low    = 1'b0;
    rdata_val      = 8'h00;
    rdata_inv_addr = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_reset_mid();
    test_partial_byte();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
